// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB > MDU > debug, with an MDU starvation guard.
// Define RF_WB_PERF_EN to build the MDU-blocked cycle counter on o_perf_mdu_block.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no MDU request pending
// ST_WAIT  | MDU request pending and denied at least once; r_starve_cnt counts denials
// ST_STALL | o_stall_req=1; WB write ignored, MDU granted
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wb_we,
    input  logic [4:0]        i_wb_wa,
    input  logic [DATA_W-1:0] i_wb_wd,
    input  logic              i_mdu_valid,
    input  logic [4:0]        i_mdu_wa,
    input  logic [DATA_W-1:0] i_mdu_wd,
    output logic              o_mdu_ready,
    input  logic              i_dbg_valid,
    input  logic [4:0]        i_dbg_wa,
    input  logic [DATA_W-1:0] i_dbg_wd,
    output logic              o_dbg_ready,
    output logic              o_stall_req,
    output logic              o_rf_we,
    output logic [4:0]        o_rf_wa,
    output logic [DATA_W-1:0] o_rf_wd,
    output logic [31:0]       o_perf_mdu_block
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_MAX_W = 8'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_starve_cnt;
    logic [7:0]        w_starve_cnt_nxt;
    logic [7:0]        w_starve_cnt_inc;
    logic              r_stall_req;
    logic              r_rf_we;
    logic [4:0]        r_rf_wa;
    logic [DATA_W-1:0] r_rf_wd;

    logic              w_in_stall;
    logic              w_wb_grant;
    logic              w_mdu_grant;
    logic              w_dbg_grant;
    logic              w_mdu_denied;
    logic              w_any_grant;
    logic [4:0]        w_sel_wa;
    logic [DATA_W-1:0] w_sel_wd;
    logic              w_rf_write;

    // Grant resolution; in STALL the WB request is masked and debug is locked out.
    always_comb begin
        w_in_stall   = (r_state == ST_STALL);
        w_wb_grant   = i_wb_we && !w_in_stall;
        w_mdu_grant  = i_mdu_valid && !w_wb_grant;
        w_dbg_grant  = i_dbg_valid && !w_wb_grant && !i_mdu_valid && !w_in_stall;
        w_mdu_denied = i_mdu_valid && !w_mdu_grant;
        w_any_grant  = w_wb_grant || w_mdu_grant || w_dbg_grant;
    end

    always_comb begin
        w_sel_wa = '0;
        w_sel_wd = '0;
        if (w_wb_grant) begin
            w_sel_wa = i_wb_wa;
            w_sel_wd = i_wb_wd;
        end else if (w_mdu_grant) begin
            w_sel_wa = i_mdu_wa;
            w_sel_wd = i_mdu_wd;
        end else if (w_dbg_grant) begin
            w_sel_wa = i_dbg_wa;
            w_sel_wd = i_dbg_wd;
        end
        // x0 writes still handshake but never reach the register file.
        w_rf_write = w_any_grant && (w_sel_wa != 5'd0);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_stall_req  <= (w_state_nxt == ST_STALL);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt      = r_state;
        w_starve_cnt_nxt = r_starve_cnt;
        w_starve_cnt_inc = r_starve_cnt + 8'd1;
        case (r_state)
            ST_IDLE: begin
                if (w_mdu_denied) begin
                    w_starve_cnt_nxt = 8'd1;
                    w_state_nxt      = (8'd1 >= STARVE_MAX_W) ? ST_STALL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_mdu_denied) begin
                    w_starve_cnt_nxt = w_starve_cnt_inc;
                    w_state_nxt      = (w_starve_cnt_inc >= STARVE_MAX_W) ? ST_STALL : ST_WAIT;
                end else begin
                    w_starve_cnt_nxt = '0;
                    w_state_nxt      = ST_IDLE;
                end
            end
            ST_STALL: begin
                // MDU is always granted here, so a stall lasts exactly one cycle.
                if (w_mdu_grant || !i_mdu_valid) begin
                    w_starve_cnt_nxt = '0;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_starve_cnt_nxt = '0;
                w_state_nxt      = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_mdu_ready = w_mdu_grant;
        o_dbg_ready = w_dbg_grant;
        o_stall_req = r_stall_req;
        o_rf_we     = r_rf_we;
        o_rf_wa     = r_rf_wa;
        o_rf_wd     = r_rf_wd;
    end

    // Write port register; address/data hold when nothing is written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rf_we <= 1'b0;
            r_rf_wa <= '0;
            r_rf_wd <= '0;
        end else begin
            r_rf_we <= w_rf_write;
            if (w_rf_write) begin
                r_rf_wa <= w_sel_wa;
                r_rf_wd <= w_sel_wd;
            end
        end
    end

`ifdef RF_WB_PERF_EN
    logic [31:0] r_perf_mdu_block;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_mdu_block <= '0;
        end else if (w_mdu_denied) begin
            r_perf_mdu_block <= r_perf_mdu_block + 32'd1;
        end
    end

    assign o_perf_mdu_block = r_perf_mdu_block;
`else
    assign o_perf_mdu_block = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: priority, starvation stall, x0 writes, reset mid-stall.
// Expected perf counter values follow RF_WB_PERF_EN.
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
`ifdef RF_WB_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_we;
    logic [4:0]        wb_wa;
    logic [DATA_W-1:0] wb_wd;
    logic              mdu_valid;
    logic [4:0]        mdu_wa;
    logic [DATA_W-1:0] mdu_wd;
    logic              mdu_ready;
    logic              dbg_valid;
    logic [4:0]        dbg_wa;
    logic [DATA_W-1:0] dbg_wd;
    logic              dbg_ready;
    logic              stall_req;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [31:0]       perf_mdu_block;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(8)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_wb_we          (wb_we),
        .i_wb_wa          (wb_wa),
        .i_wb_wd          (wb_wd),
        .i_mdu_valid      (mdu_valid),
        .i_mdu_wa         (mdu_wa),
        .i_mdu_wd         (mdu_wd),
        .o_mdu_ready      (mdu_ready),
        .i_dbg_valid      (dbg_valid),
        .i_dbg_wa         (dbg_wa),
        .i_dbg_wd         (dbg_wd),
        .o_dbg_ready      (dbg_ready),
        .o_stall_req      (stall_req),
        .o_rf_we          (rf_we),
        .o_rf_wa          (rf_wa),
        .o_rf_wd          (rf_wd),
        .o_perf_mdu_block (perf_mdu_block)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
        chk({tag, ".wa"}, {27'd0, rf_wa}, {27'd0, wa});
        chk({tag, ".wd"}, rf_wd, wd);
    endtask

    initial begin
        rst = 1'b1;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        mdu_valid = 1'b0; mdu_wa = '0; mdu_wd = '0;
        dbg_valid = 1'b0; dbg_wa = '0; dbg_wd = '0;
        #2;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        settle();
        chk_rf("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.stall", {31'd0, stall_req}, 32'd0);
        chk("reset.perf", perf_mdu_block, 32'd0);
        chk("reset.mdu_ready", {31'd0, mdu_ready}, 32'd0);
        chk("reset.dbg_ready", {31'd0, dbg_ready}, 32'd0);

        // Lone pipeline write, then idle cycle holds address/data
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h1234;
        tick();
        chk_rf("wb_single", 1'b1, 5'd5, 32'h1234);
        wb_we = 1'b0;
        tick();
        chk_rf("idle_hold", 1'b0, 5'd5, 32'h1234);

        // Pipeline beats MDU, MDU granted once pipeline drops
        wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'hAAAA;
        mdu_valid = 1'b1; mdu_wa = 5'd9; mdu_wd = 32'hBBBB;
        settle();
        chk("prio.mdu_ready_lose", {31'd0, mdu_ready}, 32'd0);
        tick();
        chk_rf("prio.wb", 1'b1, 5'd7, 32'hAAAA);
        wb_we = 1'b0;
        settle();
        chk("prio.mdu_ready_win", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk_rf("prio.mdu", 1'b1, 5'd9, 32'hBBBB);
        mdu_valid = 1'b0;

        // Starvation: 8 denied cycles, stall in cycle 9
        wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h3333;
        mdu_valid = 1'b1; mdu_wa = 5'd4; mdu_wd = 32'h4444;
        for (int c = 1; c <= 8; c++) begin
            settle();
            chk($sformatf("starve.c%0d.mdu_ready", c), {31'd0, mdu_ready}, 32'd0);
            chk($sformatf("starve.c%0d.stall", c), {31'd0, stall_req}, 32'd0);
            tick();
            chk_rf($sformatf("starve.c%0d.rf", c), 1'b1, 5'd3, 32'h3333);
        end
        dbg_valid = 1'b1; dbg_wa = 5'd6; dbg_wd = 32'h6666;
        settle();
        chk("stall.stall_req", {31'd0, stall_req}, 32'd1);
        chk("stall.mdu_ready", {31'd0, mdu_ready}, 32'd1);
        chk("stall.dbg_ready", {31'd0, dbg_ready}, 32'd0);
        chk("stall.perf", perf_mdu_block, (PERF_ON != 0) ? 32'd9 : 32'd0);
        tick();
        chk_rf("stall.mdu_write", 1'b1, 5'd4, 32'h4444);
        chk("unstall.stall_req", {31'd0, stall_req}, 32'd0);
        mdu_valid = 1'b0;
        settle();
        chk("unstall.dbg_ready", {31'd0, dbg_ready}, 32'd0);
        tick();
        chk_rf("unstall.wb_replay", 1'b1, 5'd3, 32'h3333);
        wb_we = 1'b0;
        settle();
        chk("dbg.ready", {31'd0, dbg_ready}, 32'd1);
        tick();
        chk_rf("dbg.write", 1'b1, 5'd6, 32'h6666);
        dbg_valid = 1'b0;

        // MDU write to x0: handshake completes, no RF write, address held
        mdu_valid = 1'b1; mdu_wa = 5'd0; mdu_wd = 32'hDEAD;
        settle();
        chk("x0.mdu_ready", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk_rf("x0.rf", 1'b0, 5'd6, 32'h6666);
        mdu_valid = 1'b0;

        // MDU beats debug; debug follows one cycle later
        dbg_valid = 1'b1; dbg_wa = 5'd10; dbg_wd = 32'hD0;
        mdu_valid = 1'b1; mdu_wa = 5'd11; mdu_wd = 32'hE0;
        settle();
        chk("md.mdu_ready", {31'd0, mdu_ready}, 32'd1);
        chk("md.dbg_ready_lose", {31'd0, dbg_ready}, 32'd0);
        tick();
        chk_rf("md.mdu", 1'b1, 5'd11, 32'hE0);
        mdu_valid = 1'b0;
        settle();
        chk("md.dbg_ready_win", {31'd0, dbg_ready}, 32'd1);
        tick();
        chk_rf("md.dbg", 1'b1, 5'd10, 32'hD0);
        dbg_valid = 1'b0;

        // Reset asserted while in STALL
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_we = 1'b1; wb_wa = 5'd12; wb_wd = 32'hC0C0;
        mdu_valid = 1'b1; mdu_wa = 5'd13; mdu_wd = 32'hD0D0;
        for (int c = 0; c < 8; c++) tick();
        settle();
        chk("rststall.stall_before", {31'd0, stall_req}, 32'd1);
        chk("rststall.perf_before", perf_mdu_block, (PERF_ON != 0) ? 32'd8 : 32'd0);
        rst = 1'b1;
        tick();
        chk_rf("rststall.rf", 1'b0, 5'd0, 32'h0);
        chk("rststall.stall", {31'd0, stall_req}, 32'd0);
        chk("rststall.perf", perf_mdu_block, 32'd0);
        rst = 1'b0;
        wb_we = 1'b0; mdu_valid = 1'b0;
        tick();
        chk("post.rf_we", {31'd0, rf_we}, 32'd0);
        chk("post.stall", {31'd0, stall_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
